// File: rtl/enc_input_cond_if.sv
// Pin-side signal bundle for the rotary-encoder input conditioner.
//
// Carries the three raw board pins and the cleaned levels/pulses.
//   master : board/bench side, drives the raw pins, observes the results
//   slave  : the conditioner, samples the raw pins, drives the results
//
// Signals:
//   s1_raw, s2_raw   encoder channels A/B, idle high, asynchronous
//   key_n_raw        push-button, active low, asynchronous
//   s1_db, s2_db     debounced channels A/B
//   key_level        debounced key, 1 = pressed
//   key_press        one-cycle pulse on debounced press
//   key_release      one-cycle pulse on debounced release
//   key_long         one-cycle long-press pulse (0 unless LONG_PRESS_EN)
interface enc_input_cond_if;
  logic s1_raw;
  logic s2_raw;
  logic key_n_raw;
  logic s1_db;
  logic s2_db;
  logic key_level;
  logic key_press;
  logic key_release;
  logic key_long;

  modport master (
    output s1_raw, s2_raw, key_n_raw,
    input  s1_db, s2_db, key_level, key_press, key_release, key_long
  );

  modport slave (
    input  s1_raw, s2_raw, key_n_raw,
    output s1_db, s2_db, key_level, key_press, key_release, key_long
  );
endinterface

// File: rtl/enc_input_cond.sv
// Input conditioner between the board pins and the rotary-encoder decoder.
//
// Each of s1/s2/key_n goes through a two-flop synchroniser and an
// independent debounce counter. The debounced key drives a small FSM that
// turns level changes into one-cycle press/release pulses.
//
// Optional feature macro: LONG_PRESS_EN
//   defined   : hold counter, K_HELD state and the key_long pulse exist
//   undefined : FSM has only K_UP/K_DOWN and key_long is constant 0
//
// Parameters:
//   DEB_CYCLES  cycles a synchronised input must hold a new value (>= 1)
//   LONG_CYCLES key hold time for a long press (LONG_PRESS_EN only)
//
// Ports:
//   clk   system clock
//   rst   asynchronous, active-high reset
//   pins  enc_input_cond_if.slave bundle (raw pins in, clean signals out)
module enc_input_cond #(
  parameter int unsigned DEB_CYCLES  = 50000,
  parameter int unsigned LONG_CYCLES = 50000000
) (
  input logic            clk,
  input logic            rst,
  enc_input_cond_if.slave pins
);

  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  // The toggle happens on the edge where the counter would reach
  // DEB_CYCLES, so the stored count never exceeds DEB_CYCLES-1.
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  // Channel order: [0] = s1, [1] = s2, [2] = key_n.
  logic [2:0]    raw_in;
  logic [2:0]    sync1_q, sync1_d;
  logic [2:0]    sync2_q, sync2_d;
  logic [2:0]    stable_q, stable_d;
  logic [DW-1:0] cnt_q [3];
  logic [DW-1:0] cnt_d [3];
  logic          key_level;

  assign raw_in = {pins.key_n_raw, pins.s2_raw, pins.s1_raw};

  // Synchroniser stages are straight copies; the debounce counter of a
  // channel runs only while its synchronised value disagrees with the
  // stable value and is cleared by any agreeing cycle.
  always_comb begin
    sync1_d  = raw_in;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Pins idle high, so the sync chain and stable values reset to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 3'b111;
      sync2_q  <= 3'b111;
      stable_q <= 3'b111;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign key_level = ~stable_q[2];

  // ---------------------------------------------------------------------
  // Key event FSM
  // ---------------------------------------------------------------------
`ifdef LONG_PRESS_EN
  typedef enum logic [1:0] {
    K_UP   = 2'd0,
    K_DOWN = 2'd1,
    K_HELD = 2'd2
  } key_state_e;

  localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

  logic [HW-1:0] hold_q, hold_d;
`else
  typedef enum logic [1:0] {
    K_UP   = 2'd0,
    K_DOWN = 2'd1
  } key_state_e;
`endif

  key_state_e state_q, state_d;
  logic       press_q, press_d;
  logic       release_q, release_d;
`ifdef LONG_PRESS_EN
  logic       long_q, long_d;
`endif

  // Pulses are registered, so they appear the cycle after key_level moves.
  // Each state only ever raises one kind of pulse, so press and release
  // can never coincide. Any unused encoding falls back to K_UP.
  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef LONG_PRESS_EN
    long_d    = 1'b0;
    hold_d    = hold_q;
`endif
    case (state_q)
      K_UP: begin
`ifdef LONG_PRESS_EN
        hold_d = '0;
`endif
        if (key_level) begin
          press_d = 1'b1;
          state_d = K_DOWN;
        end
      end
      K_DOWN: begin
        if (!key_level) begin
          release_d = 1'b1;
          state_d   = K_UP;
`ifdef LONG_PRESS_EN
          hold_d    = '0;
`endif
        end
`ifdef LONG_PRESS_EN
        else begin
          // Saturating hold count; the long press fires on the cycle
          // the count reaches LONG_CYCLES.
          if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
          end
          if (hold_d == HOLD_MAX) begin
            long_d  = 1'b1;
            state_d = K_HELD;
          end
        end
`endif
      end
`ifdef LONG_PRESS_EN
      K_HELD: begin
        if (!key_level) begin
          release_d = 1'b1;
          state_d   = K_UP;
          hold_d    = '0;
        end
      end
`endif
      default: begin
        state_d = K_UP;
`ifdef LONG_PRESS_EN
        hold_d  = '0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= K_UP;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef LONG_PRESS_EN
      long_q    <= 1'b0;
      hold_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef LONG_PRESS_EN
      long_q    <= long_d;
      hold_q    <= hold_d;
`endif
    end
  end

  assign pins.s1_db       = stable_q[0];
  assign pins.s2_db       = stable_q[1];
  assign pins.key_level   = key_level;
  assign pins.key_press   = press_q;
  assign pins.key_release = release_q;
`ifdef LONG_PRESS_EN
  assign pins.key_long    = long_q;
`else
  // LONG_CYCLES has no effect in this build; the expression is constant 0.
  assign pins.key_long    = 1'b0 & (LONG_CYCLES != 0);
`endif

endmodule

// File: tb/tb_enc_input_cond.sv
// Directed bench for enc_input_cond with DEB_CYCLES=4, LONG_CYCLES=20.
// Edge indices below count the first edge that samples a pin change as 1,
// so a clean change shows on the debounced output after edge 6.
module tb_enc_input_cond;

  logic clk = 1'b0;
  logic rst;
  int   vectors    = 0;
  int   miscompares = 0;

  enc_input_cond_if bus ();

  enc_input_cond #(
    .DEB_CYCLES (4),
    .LONG_CYCLES(20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .pins(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic s1, input logic s2, input logic key_n);
    bus.s1_raw    = s1;
    bus.s2_raw    = s2;
    bus.key_n_raw = key_n;
  endtask

  // Advance one edge and step clear of it before looking at outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " s1_db"}, bus.s1_db, 1);
    checkOutput({tag, " s2_db"}, bus.s2_db, 1);
    checkOutput({tag, " key_level"}, bus.key_level, 0);
    checkOutput({tag, " key_press"}, bus.key_press, 0);
    checkOutput({tag, " key_release"}, bus.key_release, 0);
    checkOutput({tag, " key_long"}, bus.key_long, 0);
  endtask

  logic s1_hist [48];
  logic s2_hist [48];

  initial begin
    int press_at, release_at, long_at, level_cnt, low_cnt, first_low;
    int press_cnt, release_cnt, long_cnt, both_cnt;
    logic exp1, exp2;

    // ---------------- reset and idle ----------------
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (3) tick();
    checkIdle("in_reset");
    rst = 1'b0;
    for (int n = 0; n < 50; n++) begin
      tick();
      checkIdle("idle");
    end

    // ---------------- s1 falling edge latency ----------------
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int n = 1; n <= 8; n++) begin
      tick();
      checkOutput($sformatf("s1_fall n=%0d", n), bus.s1_db, (n >= 6) ? 0 : 1);
      checkOutput($sformatf("s2_hold n=%0d", n), bus.s2_db, 1);
    end
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (10) tick();
    checkOutput("s1_restored", bus.s1_db, 1);

    // ---------------- short glitches on s2 must be rejected ----------------
    for (int r = 0; r < 10; r++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      repeat (3) begin
        tick();
        checkOutput($sformatf("s2_glitch r=%0d", r), bus.s2_db, 1);
      end
      applyStimulus(1'b1, 1'b1, 1'b1);
      repeat (3) begin
        tick();
        checkOutput($sformatf("s2_gap r=%0d", r), bus.s2_db, 1);
      end
    end

    // A pulse of exactly DEB_CYCLES passes through, 4 cycles wide.
    repeat (5) tick();
    applyStimulus(1'b1, 1'b0, 1'b1);
    low_cnt   = 0;
    first_low = -1;
    for (int n = 1; n <= 14; n++) begin
      if (n == 5) applyStimulus(1'b1, 1'b1, 1'b1);
      tick();
      if (bus.s2_db == 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = n;
      end
    end
    checkOutput("s2_edge_pulse_width", low_cnt, 4);
    checkOutput("s2_edge_pulse_start", first_low, 6);

    // ---------------- key: 10 cycles low ----------------
    repeat (5) tick();
    applyStimulus(1'b1, 1'b1, 1'b0);
    press_at = -1; release_at = -1; level_cnt = 0;
    press_cnt = 0; release_cnt = 0; both_cnt = 0; long_cnt = 0;
    for (int n = 1; n <= 30; n++) begin
      if (n == 11) applyStimulus(1'b1, 1'b1, 1'b1);
      tick();
      if (bus.key_level) level_cnt++;
      if (bus.key_press) begin press_cnt++; press_at = n; end
      if (bus.key_release) begin release_cnt++; release_at = n; end
      if (bus.key_press && bus.key_release) both_cnt++;
      if (bus.key_long) long_cnt++;
    end
    checkOutput("key_level_cycles", level_cnt, 10);
    checkOutput("key_press_count", press_cnt, 1);
    checkOutput("key_press_index", press_at, 7);
    checkOutput("key_release_count", release_cnt, 1);
    checkOutput("key_release_index", release_at, 17);
    checkOutput("key_press_and_release", both_cnt, 0);
    checkOutput("key_short_no_long", long_cnt, 0);

    // ---------------- CW quadrature, 8-cycle phases ----------------
    repeat (5) tick();
    for (int i = 0; i < 48; i++) begin
      s1_hist[i] = (i < 16) ? 1'b0 : 1'b1;
      s2_hist[i] = (i >= 8 && i < 32) ? 1'b0 : 1'b1;
      applyStimulus(s1_hist[i], s2_hist[i], 1'b1);
      tick();
      // Output after edge n = i+1 follows the pin value set 6 edges earlier.
      exp1 = (i >= 5) ? s1_hist[i-5] : 1'b1;
      exp2 = (i >= 5) ? s2_hist[i-5] : 1'b1;
      checkOutput($sformatf("quad s1 n=%0d", i + 1), bus.s1_db, exp1);
      checkOutput($sformatf("quad s2 n=%0d", i + 1), bus.s2_db, exp2);
    end

    // ---------------- key held 30 cycles ----------------
    repeat (5) tick();
    applyStimulus(1'b1, 1'b1, 1'b0);
    press_at = -1; release_at = -1; long_at = -1;
    press_cnt = 0; release_cnt = 0; long_cnt = 0;
    for (int n = 1; n <= 45; n++) begin
      if (n == 31) applyStimulus(1'b1, 1'b1, 1'b1);
      tick();
      if (bus.key_press) begin press_cnt++; press_at = n; end
      if (bus.key_release) begin release_cnt++; release_at = n; end
      if (bus.key_long) begin long_cnt++; long_at = n; end
    end
    checkOutput("hold_press_index", press_at, 7);
    checkOutput("hold_press_count", press_cnt, 1);
    checkOutput("hold_release_index", release_at, 37);
    checkOutput("hold_release_count", release_cnt, 1);
`ifdef LONG_PRESS_EN
    checkOutput("hold_long_count", long_cnt, 1);
    checkOutput("hold_long_index", long_at, 27);
`else
    checkOutput("hold_long_count", long_cnt, 0);
`endif

    // ---------------- reset while the key is held ----------------
    repeat (5) tick();
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (12) tick();
    checkOutput("pre_reset_key_level", bus.key_level, 1);
    rst = 1'b1;
    #1;
    checkIdle("mid_reset");
    tick();
    checkIdle("mid_reset_clocked");
    rst = 1'b0;
    press_at = -1; release_cnt = 0; press_cnt = 0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (bus.key_press) begin press_cnt++; press_at = n; end
      if (bus.key_release) release_cnt++;
    end
    checkOutput("post_reset_no_release", release_cnt, 0);
    checkOutput("post_reset_press_index", press_at, 7);
    checkOutput("post_reset_press_count", press_cnt, 1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    release_cnt = 0;
    repeat (12) begin
      tick();
      if (bus.key_release) release_cnt++;
    end
    checkOutput("post_reset_release_count", release_cnt, 1);
    checkOutput("final_key_level", bus.key_level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/enc_input_cond.md
Name: enc_input_cond

Overview:
Input conditioner between the board pins and the rotary-encoder decoder. Synchronises and debounces the quadrature lines s1/s2 and the push-button key, and produces clean levels plus one-cycle press/release pulses. The cleaned s1_db/s2_db feed the decoder's s1/s2 inputs; key_level feeds its key input.

Parameters:
DEB_CYCLES, 50000, consecutive clk cycles an input must hold a new value before the debounced output follows (legal range ≥1; 1 ms at 50 MHz).
LONG_CYCLES, 50000000, key hold time in clk cycles for a long-press event (used only with LONG_PRESS_EN).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
s1_raw  in  1  encoder channel A pin, idle high, asynchronous to clk
s2_raw  in  1  encoder channel B pin, idle high, asynchronous to clk
key_n_raw  in  1  push-button pin, active-low, asynchronous to clk
s1_db  out  1  debounced channel A
s2_db  out  1  debounced channel B
key_level  out  1  debounced key, 1 = pressed
key_press  out  1  one-cycle pulse on debounced press
key_release  out  1  one-cycle pulse on debounced release
key_long  out  1  one-cycle long-press pulse (tied 0 without LONG_PRESS_EN)

Behaviour:
- Reset: all sync flops = 1 (idle level of pins), s1_db = s2_db = 1, key_level = 0, all pulses = 0, all counters = 0, key FSM = K_UP.
- Synchroniser: two-flop chain per input; no logic between the flops.
- Debounce, per channel, independent: counter width $clog2(DEB_CYCLES+1). Each edge where sync output ≠ current stable value → counter+1; on the edge where the counter would reach DEB_CYCLES, stable value toggles and counter clears. Any edge where sync output = stable value clears the counter. Counter never wraps.
- Latency: a clean pin change appears on the debounced output exactly 2+DEB_CYCLES clock edges after the first edge that samples it. A glitch shorter than DEB_CYCLES synchronised cycles produces no output change.
- key_level = inverted stable value of key_n channel.
- Key FSM (registered, uses key_level):
  K_UP: key_level rises → key_press = 1 for one cycle, go K_DOWN.
  K_DOWN: key_level falls → key_release = 1 for one cycle, go K_UP. Hold counter increments while in K_DOWN (LONG_PRESS_EN only).
  K_HELD (LONG_PRESS_EN only): entered from K_DOWN when the hold counter reaches LONG_CYCLES; key_long = 1 on the entry cycle only. key_level falls → key_release pulse, go K_UP.
- Pulses are asserted the cycle after key_level changes; press and release are never asserted in the same cycle.
- Hold counter clears on every K_UP entry and saturates at LONG_CYCLES.
- Reset mid-operation: all state returns to reset values immediately, with no pulse on deassertion. If the pin is already low at reset release, a press is reported after 2+DEB_CYCLES+1 cycles.
- Illegal FSM encoding → K_UP.

Optional Feature:
LONG_PRESS_EN: when defined, compiles in the hold counter, the K_HELD state and key_long. When undefined, the FSM has only K_UP/K_DOWN, no hold counter exists, and key_long is constant 0.

Test Plan:
(All with DEB_CYCLES=4 and LONG_CYCLES=20.)
- Reset, pins idle high → s1_db=s2_db=1, key_level=0, no pulses for 50 cycles.
- s1_raw driven 1→0 and held → s1_db falls exactly 6 edges after the first sampling edge; s2_db unchanged.
- s2_raw low for 3 cycles then high → s2_db stays 1 and the counter returns to 0; repeated 10 times → s2_db never toggles.
- key_n_raw low for 10 cycles then high → key_level high for ~10 cycles; exactly one key_press and one key_release pulse, each 1 cycle wide.
- CW quadrature sequence with 8-cycle phases (s1 low, s2 low, s1 high, s2 high) → s1_db/s2_db reproduce the same order, each delayed by 6 cycles.
- LONG_PRESS_EN defined, key held 30 cycles → key_press, then key_long exactly 20 cycles after key_press, then key_release on release. Assert rst while held → all outputs reset and no release pulse.
